// File: rtl/ex_wb_pkg.sv
// Shared definitions for the EX->WB elastic pipeline stage.
// Default widths, and the payload layout carried from EX to WB.
package ex_wb_pkg;

    localparam int DATA_W_DEF     = 8;
    localparam int REG_ADDR_W_DEF = 3;
    localparam int FWD_PORTS_DEF  = 2;

    typedef struct packed {
        logic [DATA_W_DEF-1:0]     shift_result;
        logic [DATA_W_DEF-1:0]     data1;
        logic                      reg_write;
        logic                      sm_ctrl;
        logic [REG_ADDR_W_DEF-1:0] wr_reg_num;
    } ex_wb_payload_t;

endpackage

// File: rtl/ex_wb_pipe_buf_if.sv
// Bundle of the EX-side, WB-side and forwarding-lookup signals of ex_wb_pipe_buf.
// The stage itself uses the slave modport; the surrounding pipeline uses master.
interface ex_wb_pipe_buf_if #(
    parameter int DATA_W     = ex_wb_pkg::DATA_W_DEF,
    parameter int REG_ADDR_W = ex_wb_pkg::REG_ADDR_W_DEF,
    parameter int FWD_PORTS  = ex_wb_pkg::FWD_PORTS_DEF
) ();

    logic                            flush;

    logic                            in_valid;
    logic                            in_ready;
    logic [DATA_W-1:0]               in_shift_result;
    logic [DATA_W-1:0]               in_data1;
    logic                            in_reg_write;
    logic                            in_sm_ctrl;
    logic [REG_ADDR_W-1:0]           in_wr_reg_num;

    logic                            out_valid;
    logic                            out_ready;
    logic [DATA_W-1:0]               out_shift_result;
    logic [DATA_W-1:0]               out_data1;
    logic                            out_reg_write;
    logic                            out_sm_ctrl;
    logic [REG_ADDR_W-1:0]           out_wr_reg_num;
    logic [DATA_W-1:0]               out_wb_data;

    logic [FWD_PORTS*REG_ADDR_W-1:0] fwd_rs_num;
    logic [FWD_PORTS-1:0]            fwd_hit;
    logic [FWD_PORTS*DATA_W-1:0]     fwd_data;

    modport slave (
        input  flush,
        input  in_valid, in_shift_result, in_data1, in_reg_write, in_sm_ctrl, in_wr_reg_num,
        output in_ready,
        output out_valid, out_shift_result, out_data1, out_reg_write, out_sm_ctrl,
        output out_wr_reg_num, out_wb_data,
        input  out_ready,
        input  fwd_rs_num,
        output fwd_hit, fwd_data
    );

    modport master (
        output flush,
        output in_valid, in_shift_result, in_data1, in_reg_write, in_sm_ctrl, in_wr_reg_num,
        input  in_ready,
        input  out_valid, out_shift_result, out_data1, out_reg_write, out_sm_ctrl,
        input  out_wr_reg_num, out_wb_data,
        output out_ready,
        output fwd_rs_num,
        input  fwd_hit, fwd_data
    );

endinterface

// File: rtl/ex_wb_fwd_match.sv
// One forwarding lookup port: compares a source register against the main and
// skid entries and returns the youngest matching write-back value.
module ex_wb_fwd_match import ex_wb_pkg::*; #(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic [REG_ADDR_W-1:0] rs_num,
    input  logic                  main_valid,
    input  logic                  main_reg_write,
    input  logic [REG_ADDR_W-1:0] main_num,
    input  logic [DATA_W-1:0]     main_wb_data,
    input  logic                  skid_valid,
    input  logic                  skid_reg_write,
    input  logic [REG_ADDR_W-1:0] skid_num,
    input  logic [DATA_W-1:0]     skid_wb_data,
    output logic                  hit,
    output logic [DATA_W-1:0]     data
);

    logic skid_match;
    logic main_match;

    assign skid_match = skid_valid & skid_reg_write & (skid_num == rs_num);
    assign main_match = main_valid & main_reg_write & (main_num == rs_num);

    // The skid entry was accepted after the main entry, so it holds the newer value.
    always_comb begin
        hit  = skid_match | main_match;
        data = '0;
        if (skid_match) begin
            data = skid_wb_data;
        end else if (main_match) begin
            data = main_wb_data;
        end
    end

endmodule

// File: rtl/ex_wb_pipe_buf.sv
// Elastic EX->WB pipeline register with 2-entry skid buffer, flush and forwarding.
// Optional build macro EX_WB_PERF_CNT_EN adds a saturating 16-bit stall_cycles counter.
module ex_wb_pipe_buf import ex_wb_pkg::*; #(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int FWD_PORTS  = FWD_PORTS_DEF
) (
    input  logic Clk,
    input  logic Reset,
    ex_wb_pipe_buf_if.slave bus
`ifdef EX_WB_PERF_CNT_EN
    ,
    output logic [15:0] stall_cycles
`endif
);

    typedef struct packed {
        logic [DATA_W-1:0]     shift_result;
        logic [DATA_W-1:0]     data1;
        logic                  reg_write;
        logic                  sm_ctrl;
        logic [REG_ADDR_W-1:0] wr_reg_num;
    } payload_t;

    payload_t          in_payload;
    payload_t          main_q;
    payload_t          skid_q;
    logic              main_valid;
    logic              skid_valid;
    logic              accept;
    logic              consume;
    logic [DATA_W-1:0] main_wb_data;
    logic [DATA_W-1:0] skid_wb_data;

    assign in_payload = '{
        shift_result: bus.in_shift_result,
        data1:        bus.in_data1,
        reg_write:    bus.in_reg_write,
        sm_ctrl:      bus.in_sm_ctrl,
        wr_reg_num:   bus.in_wr_reg_num
    };

    assign bus.in_ready = !skid_valid;
    assign accept       = bus.in_valid & !skid_valid;
    assign consume      = main_valid & bus.out_ready;

    // A full skid blocks accept, so a refill from skid never sees a new input.
    // Flush keeps the payload bits; only the valid flags are cleared.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (bus.flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!main_valid || consume) begin
            if (skid_valid) begin
                main_q     <= skid_q;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else begin
                main_q     <= in_payload;
                main_valid <= accept;
            end
        end else if (accept) begin
            skid_q     <= in_payload;
            skid_valid <= 1'b1;
        end
    end

    assign main_wb_data = main_q.sm_ctrl ? main_q.shift_result : main_q.data1;
    assign skid_wb_data = skid_q.sm_ctrl ? skid_q.shift_result : skid_q.data1;

    assign bus.out_valid        = main_valid;
    assign bus.out_shift_result = main_q.shift_result;
    assign bus.out_data1        = main_q.data1;
    assign bus.out_reg_write    = main_q.reg_write & main_valid;
    assign bus.out_sm_ctrl      = main_q.sm_ctrl;
    assign bus.out_wr_reg_num   = main_q.wr_reg_num;
    assign bus.out_wb_data      = main_wb_data;

    logic [FWD_PORTS-1:0]        fwd_hit;
    logic [FWD_PORTS*DATA_W-1:0] fwd_data;

    for (genvar k = 0; k < FWD_PORTS; k++) begin : g_fwd
        ex_wb_fwd_match #(
            .DATA_W     (DATA_W),
            .REG_ADDR_W (REG_ADDR_W)
        ) u_match (
            .rs_num         (bus.fwd_rs_num[k*REG_ADDR_W +: REG_ADDR_W]),
            .main_valid     (main_valid),
            .main_reg_write (main_q.reg_write),
            .main_num       (main_q.wr_reg_num),
            .main_wb_data   (main_wb_data),
            .skid_valid     (skid_valid),
            .skid_reg_write (skid_q.reg_write),
            .skid_num       (skid_q.wr_reg_num),
            .skid_wb_data   (skid_wb_data),
            .hit            (fwd_hit[k]),
            .data           (fwd_data[k*DATA_W +: DATA_W])
        );
    end

    assign bus.fwd_hit  = fwd_hit;
    assign bus.fwd_data = fwd_data;

`ifdef EX_WB_PERF_CNT_EN
    logic [15:0] stall_q;

    // Counts cycles where WB holds a valid entry it will not take; flush leaves it alone.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            stall_q <= 16'd0;
        end else if (main_valid && !bus.out_ready && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_ex_wb_pipe_buf.sv
// Self-checking bench for ex_wb_pipe_buf: directed scenarios plus a randomized
// run against a 2-deep FIFO reference model; stall counter covered when EX_WB_PERF_CNT_EN is set.
module tb_ex_wb_pipe_buf;
    import ex_wb_pkg::*;

    localparam int DW = 8;
    localparam int AW = 3;
    localparam int NP = 2;

    logic Clk = 1'b0;
    logic Reset;
    int   errors = 0;
    int   checks = 0;

`ifdef EX_WB_PERF_CNT_EN
    logic [15:0] stall_cycles;
`endif

    always #5 Clk = ~Clk;

    ex_wb_pipe_buf_if #(.DATA_W(DW), .REG_ADDR_W(AW), .FWD_PORTS(NP)) bus ();

    ex_wb_pipe_buf #(.DATA_W(DW), .REG_ADDR_W(AW), .FWD_PORTS(NP)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
`ifdef EX_WB_PERF_CNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic present(input logic [DW-1:0] sr, input logic [DW-1:0] d1,
                           input logic rw, input logic sm, input logic [AW-1:0] rn);
        bus.in_valid        = 1'b1;
        bus.in_shift_result = sr;
        bus.in_data1        = d1;
        bus.in_reg_write    = rw;
        bus.in_sm_ctrl      = sm;
        bus.in_wr_reg_num   = rn;
    endtask

    task automatic test_reset();
        Reset          = 1'b1;
        bus.flush      = 1'b0;
        bus.out_ready  = 1'b1;
        bus.fwd_rs_num = '0;
        present(8'hFF, 8'hEE, 1'b1, 1'b1, 3'd0);
        tick();
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
        checks++; if ({bus.out_shift_result, bus.out_data1, bus.out_reg_write, bus.out_sm_ctrl, bus.out_wr_reg_num} !== '0)
            begin errors++; $display("[TB] FAIL reset_payload: got %h/%h/%b/%b/%h expected all zero", bus.out_shift_result, bus.out_data1, bus.out_reg_write, bus.out_sm_ctrl, bus.out_wr_reg_num); end
        checks++; if (bus.out_wb_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_wb_data: got %h expected 00", bus.out_wb_data); end
        checks++; if (bus.fwd_hit !== 2'b00 || bus.fwd_data !== 16'h0000) begin errors++; $display("[TB] FAIL reset_fwd: got %b/%h expected 00/0000", bus.fwd_hit, bus.fwd_data); end
        Reset = 1'b0;
        present(8'h00, 8'h00, 1'b0, 1'b0, 3'd0);
        bus.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_stream();
        logic [DW-1:0] vals [3];
        vals = '{8'h11, 8'h22, 8'h33};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            present(vals[i], 8'h5A, 1'b1, 1'b1, AW'(i));
            tick();
            checks++; if (bus.out_valid !== 1'b1 || bus.out_shift_result !== vals[i])
                begin errors++; $display("[TB] FAIL stream_%0d: got valid=%b data=%h expected valid=1 data=%h", i, bus.out_valid, bus.out_shift_result, vals[i]); end
        end
        bus.in_valid = 1'b0;
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL stream_drain: got %b expected 0", bus.out_valid); end
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b0;
        present(8'hA1, 8'h01, 1'b0, 1'b1, 3'd1);
        tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_shift_result !== 8'hA1)
            begin errors++; $display("[TB] FAIL bp_first: got valid=%b data=%h expected 1/a1", bus.out_valid, bus.out_shift_result); end
        present(8'hA2, 8'h02, 1'b0, 1'b1, 3'd2);
        tick();
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready_low: got %b expected 0", bus.in_ready); end
        present(8'hA3, 8'h03, 1'b0, 1'b1, 3'd3);
        tick();
        tick();
        checks++; if (bus.out_shift_result !== 8'hA1 || bus.in_ready !== 1'b0)
            begin errors++; $display("[TB] FAIL bp_hold: got data=%h ready=%b expected a1/0", bus.out_shift_result, bus.in_ready); end
        bus.out_ready = 1'b1;
        tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_shift_result !== 8'hA2)
            begin errors++; $display("[TB] FAIL bp_second: got valid=%b data=%h expected 1/a2", bus.out_valid, bus.out_shift_result); end
        tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_shift_result !== 8'hA3)
            begin errors++; $display("[TB] FAIL bp_third: got valid=%b data=%h expected 1/a3", bus.out_valid, bus.out_shift_result); end
        bus.in_valid = 1'b0;
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_drain: got %b expected 0", bus.out_valid); end
    endtask

    task automatic test_fwd_and_flush();
        bus.out_ready = 1'b0;
        present(8'h3C, 8'hE1, 1'b1, 1'b1, 3'd5);
        tick();
        present(8'h99, 8'h77, 1'b1, 1'b0, 3'd5);
        tick();
        bus.in_valid   = 1'b0;
        bus.fwd_rs_num = {3'd5, 3'd2};
        #1;
        checks++; if (bus.fwd_hit !== 2'b10) begin errors++; $display("[TB] FAIL fwd_hit: got %b expected 10", bus.fwd_hit); end
        checks++; if (bus.fwd_data !== 16'h7700) begin errors++; $display("[TB] FAIL fwd_data: got %h expected 7700", bus.fwd_data); end
        bus.flush = 1'b1;
        present(8'h44, 8'h55, 1'b1, 1'b1, 3'd2);
        tick();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b0 || bus.out_reg_write !== 1'b0)
            begin errors++; $display("[TB] FAIL flush_out: got valid=%b rw=%b expected 0/0", bus.out_valid, bus.out_reg_write); end
        checks++; if (bus.fwd_hit !== 2'b00 || bus.in_ready !== 1'b1)
            begin errors++; $display("[TB] FAIL flush_fwd_ready: got hit=%b ready=%b expected 00/1", bus.fwd_hit, bus.in_ready); end
    endtask

    task automatic test_reset_mid_stall();
        bus.out_ready = 1'b0;
        present(8'hC1, 8'hD1, 1'b1, 1'b1, 3'd4);
        tick();
        present(8'hC2, 8'hD2, 1'b1, 1'b0, 3'd6);
        tick();
        bus.in_valid = 1'b0;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_shift_result !== 8'h00)
            begin errors++; $display("[TB] FAIL reset_mid_stall: got valid=%b ready=%b data=%h expected 0/1/00", bus.out_valid, bus.in_ready, bus.out_shift_result); end
    endtask

    task automatic test_random(input int cycles);
        ex_wb_payload_t q[$];
        ex_wb_payload_t p;
        logic           acc;
        logic           con;
        logic           exp_hit;
        logic [DW-1:0]  exp_data;
        logic [AW-1:0]  rs;
        for (int c = 0; c < cycles; c++) begin
            p.shift_result      = DW'($urandom);
            p.data1             = DW'($urandom);
            p.reg_write         = 1'($urandom);
            p.sm_ctrl           = 1'($urandom);
            p.wr_reg_num        = AW'($urandom);
            present(p.shift_result, p.data1, p.reg_write, p.sm_ctrl, p.wr_reg_num);
            bus.in_valid        = ($urandom_range(0, 3) != 0);
            bus.out_ready       = ($urandom_range(0, 2) != 0);
            bus.flush           = ($urandom_range(0, 31) == 0);
            bus.fwd_rs_num      = (NP*AW)'($urandom);
            #1;
            checks++; if (bus.in_ready !== (q.size() < 2))
                begin errors++; $display("[TB] FAIL rnd_in_ready c=%0d: got %b expected %b", c, bus.in_ready, q.size() < 2); end
            checks++; if (bus.out_valid !== (q.size() > 0))
                begin errors++; $display("[TB] FAIL rnd_out_valid c=%0d: got %b expected %b", c, bus.out_valid, q.size() > 0); end
            if (q.size() > 0) begin
                checks++; if ({bus.out_shift_result, bus.out_data1, bus.out_sm_ctrl, bus.out_wr_reg_num} !== {q[0].shift_result, q[0].data1, q[0].sm_ctrl, q[0].wr_reg_num})
                    begin errors++; $display("[TB] FAIL rnd_payload c=%0d: got %h/%h/%b/%h expected %h/%h/%b/%h", c, bus.out_shift_result, bus.out_data1, bus.out_sm_ctrl, bus.out_wr_reg_num, q[0].shift_result, q[0].data1, q[0].sm_ctrl, q[0].wr_reg_num); end
                checks++; if (bus.out_wb_data !== (q[0].sm_ctrl ? q[0].shift_result : q[0].data1))
                    begin errors++; $display("[TB] FAIL rnd_wb_data c=%0d: got %h expected %h", c, bus.out_wb_data, q[0].sm_ctrl ? q[0].shift_result : q[0].data1); end
                checks++; if (bus.out_reg_write !== q[0].reg_write)
                    begin errors++; $display("[TB] FAIL rnd_reg_write c=%0d: got %b expected %b", c, bus.out_reg_write, q[0].reg_write); end
            end else begin
                checks++; if (bus.out_reg_write !== 1'b0)
                    begin errors++; $display("[TB] FAIL rnd_reg_write_idle c=%0d: got %b expected 0", c, bus.out_reg_write); end
            end
            for (int k = 0; k < NP; k++) begin
                rs       = bus.fwd_rs_num[k*AW +: AW];
                exp_hit  = 1'b0;
                exp_data = '0;
                for (int i = q.size() - 1; i >= 0; i--) begin
                    if (!exp_hit && q[i].reg_write && q[i].wr_reg_num == rs) begin
                        exp_hit  = 1'b1;
                        exp_data = q[i].sm_ctrl ? q[i].shift_result : q[i].data1;
                    end
                end
                checks++; if (bus.fwd_hit[k] !== exp_hit || bus.fwd_data[k*DW +: DW] !== exp_data)
                    begin errors++; $display("[TB] FAIL rnd_fwd%0d c=%0d: got %b/%h expected %b/%h", k, c, bus.fwd_hit[k], bus.fwd_data[k*DW +: DW], exp_hit, exp_data); end
            end
            acc = bus.in_valid && (q.size() < 2);
            con = (q.size() > 0) && bus.out_ready;
            if (bus.flush) begin
                q.delete();
            end else begin
                if (con) void'(q.pop_front());
                if (acc) q.push_back(p);
            end
            tick();
        end
        bus.in_valid = 1'b0;
        bus.flush    = 1'b1;
        tick();
        bus.flush    = 1'b0;
    endtask

`ifdef EX_WB_PERF_CNT_EN
    task automatic test_perf();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        checks++; if (stall_cycles !== 16'd0) begin errors++; $display("[TB] FAIL perf_reset: got %h expected 0000", stall_cycles); end
        present(8'h10, 8'h20, 1'b1, 1'b1, 3'd1);
        tick();
        bus.in_valid = 1'b0;
        repeat (5) tick();
        checks++; if (stall_cycles !== 16'd5) begin errors++; $display("[TB] FAIL perf_count: got %0d expected 5", stall_cycles); end
        repeat (70000) tick();
        checks++; if (stall_cycles !== 16'hFFFF) begin errors++; $display("[TB] FAIL perf_saturate: got %h expected ffff", stall_cycles); end
        repeat (3) tick();
        checks++; if (stall_cycles !== 16'hFFFF) begin errors++; $display("[TB] FAIL perf_hold: got %h expected ffff", stall_cycles); end
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        checks++; if (stall_cycles !== 16'd0) begin errors++; $display("[TB] FAIL perf_clear: got %h expected 0000", stall_cycles); end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_back_to_back();
        test_fwd_and_flush();
        test_reset_mid_stall();
        test_random(3000);
`ifdef EX_WB_PERF_CNT_EN
        test_perf();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
